// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX forwarding muxes and load-use hazard detection
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [2:0]    id_alu_m,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_alusrc,
  input  logic          id_uses_rt,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_dst,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_trap_of,
  input  logic          exm_regwrite,
  input  logic [RW-1:0] exm_dst,
  input  logic [DW-1:0] exm_result,
  input  logic          wb_regwrite,
  input  logic [RW-1:0] wb_dst,
  input  logic [DW-1:0] wb_result,
  output logic          hazard,
  output logic          ex_valid,
  output logic [2:0]    alu_m,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dst,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_trap_of
);
  logic          v_q, alusrc_q, rw_q, mr_q, mw_q, tr_q;
  logic [2:0]    m_q;
  logic [DW-1:0] rsd_q, rtd_q, imm_q, fwd_a, fwd_b;
  logic [RW-1:0] rs_q, rt_q, dst_q;
  assign hazard = id_valid & v_q & mr_q & (dst_q != '0) &
                  ((dst_q == id_rs) | (id_uses_rt & (dst_q == id_rt)));
  always_ff @(posedge clk) begin
    if (rst || flush || (!stall && hazard)) begin
      v_q      <= 1'b0;
      m_q      <= '0;
      rsd_q    <= '0;
      rtd_q    <= '0;
      imm_q    <= '0;
      alusrc_q <= 1'b0;
      rs_q     <= '0;
      rt_q     <= '0;
      dst_q    <= '0;
      rw_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      tr_q     <= 1'b0;
    end else if (!stall) begin
      v_q      <= id_valid;
      m_q      <= id_alu_m;
      rsd_q    <= id_rs_data;
      rtd_q    <= id_rt_data;
      imm_q    <= id_imm;
      alusrc_q <= id_alusrc;
      rs_q     <= id_rs;
      rt_q     <= id_rt;
      dst_q    <= id_dst;
      rw_q     <= id_valid & id_regwrite;
      mr_q     <= id_valid & id_memread;
      mw_q     <= id_valid & id_memwrite;
      tr_q     <= id_valid & id_trap_of;
    end
  end
  // EX/MEM beats MEM/WB; index 0 is never forwarded
  always_comb begin
    fwd_a = (exm_regwrite && exm_dst != '0 && exm_dst == rs_q) ? exm_result :
            (wb_regwrite && wb_dst != '0 && wb_dst == rs_q) ? wb_result : rsd_q;
    fwd_b = (exm_regwrite && exm_dst != '0 && exm_dst == rt_q) ? exm_result :
            (wb_regwrite && wb_dst != '0 && wb_dst == rt_q) ? wb_result : rtd_q;
  end
  assign ex_valid      = v_q;
  assign alu_m         = m_q;
  assign alu_a         = fwd_a;
  assign alu_b         = alusrc_q ? imm_q : fwd_b;
  assign ex_store_data = fwd_b;
  assign ex_dst        = dst_q;
  assign ex_regwrite   = v_q & rw_q;
  assign ex_memread    = v_q & mr_q;
  assign ex_memwrite   = v_q & mw_q;
  assign ex_trap_of    = v_q & tr_q;
endmodule
